// File: rtl/chronos_pkg.sv
// Shared types and constants for the Chronos RV32I front end.
package chronos_pkg;

    localparam int XLEN   = 32;
    localparam int INST_W = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [XLEN-1:0]   pc;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fifo.sv
// Small instruction buffer between fetch and decode; flush beats push/pop.
module inst_fifo
    import chronos_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          pop_ok;
    fetch_entry_t  mem [DEPTH];

    assign pop_ok = pop && (count != '0);

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst && !flush && push)
            mem[wr_ptr] <= push_data;
    end

    // Empty buffer presents zeros rather than stale storage.
    assign head = (count == '0) ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: owns the PC, requests words, buffers them for decode.
module fetch_unit
    import chronos_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic [XLEN-1:0]   fetch_addr,
    output logic              fetch_req,
    input  logic [INST_W-1:0] request_data,
    input  logic              fetch_data_valid,
    output logic [INST_W-1:0] inst,
    output logic [XLEN-1:0]   inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] pc;
    logic [CW-1:0]   count;
    logic            push;
    logic            pop;
    fetch_entry_t    push_data;
    fetch_entry_t    head;

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    assign fetch_req = (state == RUN) && (count < FULL)
                       && !redirect_valid && rst;
    assign fetch_addr = {2'b00, pc[XLEN-1:2]};

    assign push = fetch_req && fetch_data_valid;
    assign pop  = inst_valid && inst_ready && !redirect_valid;

    always_ff @(posedge clk) begin
        if (!rst)
            pc <= RESET_PC;
        else if (redirect_valid)
            pc <= redirect_pc & ~32'h3;
        else if (push)
            pc <= pc + 32'd4;
    end

    assign push_data.inst = request_data;
    assign push_data.pc   = pc;

    inst_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (count)
    );

    assign inst_valid = (count != '0);
    assign inst       = head.inst;
    assign inst_pc    = head.pc;

endmodule
